input_decoder_packet_sequencer: RTL and testbench

// - Read-side controller for the 32-bit input-decoder FIFO (1-cycle registered read data).
// - Pops a header word, then exactly LEN payload words.
// - Presents the header as a command and each payload word on a valid/ready stream to the GPU

---
 rtl/input_decoder_packet_sequencer_if.sv | 33 +++
 rtl/input_decoder_packet_sequencer.sv | 160 ++++++++++++++++
 tb/tb_input_decoder_packet_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_decoder_packet_sequencer_if.sv
`default_nettype none
// ============================================================================
// input_decoder_packet_sequencer_if : FIFO read side plus cmd/dat streams
// Rev 1.0
// ============================================================================
interface input_decoder_packet_sequencer_if;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;
    logic        fifo_read;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [15:0] cmd_len;
    logic        dat_valid;
    logic        dat_ready;
    logic [31:0] dat_data;
    logic        dat_last;
    logic        pkt_err;
    logic        busy;

    modport master (
        input  fifo_empty, fifo_rdata, cmd_ready, dat_ready,
        output fifo_read, cmd_valid, cmd_opcode, cmd_len,
               dat_valid, dat_data, dat_last, pkt_err, busy
    );

    modport slave (
        output fifo_empty, fifo_rdata, cmd_ready, dat_ready,
        input  fifo_read, cmd_valid, cmd_opcode, cmd_len,
               dat_valid, dat_data, dat_last, pkt_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/input_decoder_packet_sequencer.sv
`default_nettype none
// ============================================================================
// input_decoder_packet_sequencer : pops header + LEN payload words from a
// registered-read FIFO onto cmd/dat streams. Option macro: PKT_TIMEOUT_EN
// Rev 1.0
// ============================================================================
module input_decoder_packet_sequencer #(
    parameter int MAX_LEN     = 255,
    parameter int TIMEOUT_CYC = 1024
) (
    input  wire logic                        clk,
    input  wire logic                        reset,
    input_decoder_packet_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR_WAIT = 3'd1,
        HDR_OUT  = 3'd2,
        PAY_REQ  = 3'd3,
        PAY_WAIT = 3'd4,
        PAY_OUT  = 3'd5
    } state_t;

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    state_t      state_q, state_d;
    logic        run_q;
    logic [7:0]  opcode_q, opcode_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        last_q, last_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        dat_valid_q, dat_valid_d;
    logic        err_q, err_d;
    logic        rd;
    logic [15:0] hdr_len;

`ifdef PKT_TIMEOUT_EN
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] stall_q, stall_d;
`endif

    assign hdr_len = bus.fifo_rdata[15:0];

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        last_d      = last_q;
        cmd_valid_d = cmd_valid_q;
        dat_valid_d = dat_valid_q;
        err_d       = 1'b0;
        rd          = 1'b0;
`ifdef PKT_TIMEOUT_EN
        stall_d     = 16'd0;
`endif
        case (state_q)
            IDLE: begin
                // run_q holds off the first pop until one clock after reset release
                if (run_q && !bus.fifo_empty) begin
                    rd      = 1'b1;
                    state_d = HDR_WAIT;
                end
            end
            HDR_WAIT: begin
                opcode_d = bus.fifo_rdata[31:24];
                len_d    = hdr_len;
                if (hdr_len > MAX_LEN_W) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cmd_valid_d = 1'b1;
                    state_d     = HDR_OUT;
                end
            end
            HDR_OUT: begin
                if (bus.cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    cnt_d       = len_q;
                    state_d     = (len_q == 16'd0) ? IDLE : PAY_REQ;
                end
            end
            PAY_REQ: begin
                if (!bus.fifo_empty) begin
                    rd      = 1'b1;
                    state_d = PAY_WAIT;
                end
`ifdef PKT_TIMEOUT_EN
                else if (stall_q == STALL_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
`endif
            end
            PAY_WAIT: begin
                data_d      = bus.fifo_rdata;
                dat_valid_d = 1'b1;
                last_d      = (cnt_q == 16'd1);
                state_d     = PAY_OUT;
            end
            PAY_OUT: begin
                if (bus.dat_ready) begin
                    dat_valid_d = 1'b0;
                    last_d      = 1'b0;
                    cnt_d       = cnt_q - 16'd1;
                    state_d     = (cnt_q == 16'd1) ? IDLE : PAY_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            opcode_q    <= 8'd0;
            len_q       <= 16'd0;
            cnt_q       <= 16'd0;
            data_q      <= 32'd0;
            last_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            dat_valid_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef PKT_TIMEOUT_EN
            stall_q     <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            opcode_q    <= opcode_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            last_q      <= last_d;
            cmd_valid_q <= cmd_valid_d;
            dat_valid_q <= dat_valid_d;
            err_q       <= err_d;
`ifdef PKT_TIMEOUT_EN
            stall_q     <= stall_d;
`endif
        end
    end

    assign bus.fifo_read  = rd;
    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_opcode = opcode_q;
    assign bus.cmd_len    = len_q;
    assign bus.dat_valid  = dat_valid_q;
    assign bus.dat_data   = data_q;
    assign bus.dat_last   = last_q;
    assign bus.pkt_err    = err_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_input_decoder_packet_sequencer.sv
`default_nettype none
// ============================================================================
// tb_input_decoder_packet_sequencer : directed packets against a packet-level
// stream model with per-cycle protocol checks. Rev 1.0
// ============================================================================
module tb_input_decoder_packet_sequencer;
    logic clk;
    logic reset;
    input_decoder_packet_sequencer_if bus();

    input_decoder_packet_sequencer #(
        .MAX_LEN     (255),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // FIFO with registered read data
    logic [31:0] mem [64];
    int head = 0;
    int tail = 0;
    assign bus.fifo_empty = (head == tail);
    always @(posedge clk) begin
        if (bus.fifo_read) begin
            bus.fifo_rdata <= mem[head[5:0]];
            head           <= head + 1;
        end
    end

    // packet-level model: expected cmd beats, dat beats and error count
    logic [23:0] exp_cmd [$];
    logic [32:0] exp_dat [$];
    logic [32:0] beat_log [$];
    int  exp_err = 0;
    int  seen_err = 0;
    int  cmd_cnt = 0;
    bit  need_hdr = 1'b1;
    int  rem = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[tail[5:0]] = w;
        tail++;
        if (need_hdr) begin
            if (w[15:0] > 16'd255) exp_err++;
            else begin
                exp_cmd.push_back({w[31:24], w[15:0]});
                if (w[15:0] != 16'd0) begin
                    rem      = int'(w[15:0]);
                    need_hdr = 1'b0;
                end
            end
        end else begin
            exp_dat.push_back({w, rem == 1});
            rem--;
            if (rem == 0) need_hdr = 1'b1;
        end
    endtask

    function automatic logic [63:0] outs();
        return {2'b00, bus.fifo_read, bus.cmd_valid, bus.cmd_opcode, bus.cmd_len,
                bus.dat_valid, bus.dat_data, bus.dat_last, bus.pkt_err, bus.busy};
    endfunction

    // per-cycle compare against the model and stream protocol rules
    logic        prev_rd, prev_cv, prev_cr, prev_dv, prev_dr, prev_err;
    logic [23:0] prev_cmd;
    logic [32:0] prev_dat;
    always @(negedge clk) begin
        if (!reset) begin
            prev_rd = 0; prev_cv = 0; prev_cr = 0; prev_dv = 0; prev_dr = 0; prev_err = 0;
        end else begin
            if (bus.fifo_read) begin
                chk("read_when_empty", 64'(bus.fifo_empty), 0);
                chk("read_back_to_back", 64'(prev_rd), 0);
            end
            if (prev_cv && !prev_cr)
                chk("cmd_hold", {bus.cmd_valid, bus.cmd_opcode, bus.cmd_len}, {1'b1, prev_cmd});
            if (prev_dv && !prev_dr)
                chk("dat_hold", {bus.dat_valid, bus.dat_data, bus.dat_last}, {1'b1, prev_dat});
            if (bus.pkt_err) begin
                chk("err_pulse_width", 64'(prev_err), 0);
                seen_err++;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                cmd_cnt++;
                chk("cmd_expected", 64'(exp_cmd.size() != 0), 1);
                if (exp_cmd.size() != 0)
                    chk("cmd_beat", {bus.cmd_opcode, bus.cmd_len}, exp_cmd.pop_front());
            end
            if (bus.dat_valid && bus.dat_ready) begin
                beat_log.push_back({bus.dat_data, bus.dat_last});
                chk("dat_expected", 64'(exp_dat.size() != 0), 1);
                if (exp_dat.size() != 0)
                    chk("dat_beat", {bus.dat_data, bus.dat_last}, exp_dat.pop_front());
            end
            prev_rd  = bus.fifo_read;
            prev_cv  = bus.cmd_valid;
            prev_cr  = bus.cmd_ready;
            prev_dv  = bus.dat_valid;
            prev_dr  = bus.dat_ready;
            prev_err = bus.pkt_err;
            prev_cmd = {bus.cmd_opcode, bus.cmd_len};
            prev_dat = {bus.dat_data, bus.dat_last};
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_cmd.size() != 0 || exp_dat.size() != 0 || head != tail) && k < 300) begin
            tick();
            k++;
        end
        chk({name, "_drained"}, 64'(k < 300), 1);
        tick();
        tick();
        chk({name, "_idle"}, 64'(bus.busy), 0);
        chk({name, "_errors"}, 64'(seen_err), 64'(exp_err));
    endtask

    task automatic wait_dat_empty(input string name);
        int k = 0;
        while ((exp_dat.size() != 0 || head != tail) && k < 100) begin
            tick();
            k++;
        end
        chk({name, "_beat_seen"}, 64'(k < 100), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int k;
        int cmd_before;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.dat_ready = 1'b0;

        // basic packet, loaded while reset is held
        push(32'h0A000002);
        push(32'h11111111);
        push(32'h22222222);
        chk("model_cmd", 64'(exp_cmd[0]), 64'h0A0002);
        chk("model_first_not_last", 64'(exp_dat[0]), {32'h11111111, 1'b0});
        chk("model_last", 64'(exp_dat[1]), {32'h22222222, 1'b1});
        repeat (3) begin
            tick();
            chk("reset_outputs", outs(), 0);
        end
        bus.cmd_ready = 1'b1;
        bus.dat_ready = 1'b1;
        at_pos();
        reset = 1'b1;
        tick(); chk("read_at_release", 64'(bus.fifo_read), 0);
        tick(); chk("first_read", 64'(bus.fifo_read), 1);
        tick(); chk("cmd_latency_early", 64'(bus.cmd_valid), 0);
        tick(); chk("cmd_latency", 64'(bus.cmd_valid), 1);
        chk("cmd_opcode_a", 64'(bus.cmd_opcode), 64'h0A);
        chk("cmd_len_a", 64'(bus.cmd_len), 2);
        drain("pkt_a");
        chk("pkt_a_beats", 64'(beat_log.size()), 2);
        chk("pkt_a_beat0", 64'(beat_log[0]), {32'h11111111, 1'b0});
        chk("pkt_a_beat1", 64'(beat_log[1]), {32'h22222222, 1'b1});

        // zero-length packet followed at once by another header
        beat_log.delete();
        at_pos();
        push(32'h05000000);
        push(32'h06000001);
        push(32'h12345678);
        k = 0;
        while (!bus.cmd_valid && k < 20) begin tick(); k++; end
        chk("len0_cmd_seen", 64'(k < 20), 1);
        chk("len0_opcode", 64'(bus.cmd_opcode), 64'h05);
        chk("len0_len", 64'(bus.cmd_len), 0);
        tick();
        chk("len0_next_read", 64'(bus.fifo_read), 1);
        drain("len0");
        chk("len0_beats", 64'(beat_log.size()), 1);
        chk("len0_beat", 64'(beat_log[0]), {32'h12345678, 1'b1});

        // oversize header is dropped with an error pulse
        cmd_before = cmd_cnt;
        at_pos();
        push(32'h0700012C);
        chk("model_err", 64'(exp_err), 1);
        drain("len300");
        chk("len300_no_cmd", 64'(cmd_cnt), 64'(cmd_before));

        // payload backpressure for 10 cycles
        beat_log.delete();
        at_pos();
        bus.dat_ready = 1'b0;
        push(32'h0B000002);
        push(32'h55555555);
        push(32'h66666666);
        k = 0;
        while (!bus.dat_valid && k < 30) begin tick(); k++; end
        chk("bp_valid_seen", 64'(k < 30), 1);
        repeat (10) begin
            tick();
            chk("bp_data", 64'(bus.dat_data), 64'h55555555);
            chk("bp_no_read", 64'(bus.fifo_read), 0);
            chk("bp_valid", 64'(bus.dat_valid), 1);
        end
        at_pos();
        bus.dat_ready = 1'b1;
        drain("bp");
        chk("bp_beat1", 64'(beat_log[1]), {32'h66666666, 1'b1});

        // FIFO runs dry after 1 of 3 payload words
        at_pos();
        push(32'h0C000003);
        push(32'h33333333);
        wait_dat_empty("starve");
`ifdef PKT_TIMEOUT_EN
        exp_err++;
        k = 1;
        tick();
        while (!bus.pkt_err && k < 60) begin tick(); k++; end
        chk("timeout_delay", 64'(k >= 16 && k <= 18), 1);
        chk("timeout_no_last", 64'(bus.dat_last), 0);
        tick();
        chk("timeout_idle", 64'(bus.busy), 0);
        chk("timeout_errors", 64'(seen_err), 64'(exp_err));
        need_hdr = 1'b1;
        rem = 0;
        at_pos();
        push(32'h0D000002);
        push(32'h44444444);
        wait_dat_empty("starve2");
        repeat (3) tick();
`else
        repeat (20) tick();
        chk("starve_busy", 64'(bus.busy), 1);
        chk("starve_no_err", 64'(seen_err), 64'(exp_err));
        chk("starve_no_valid", 64'(bus.dat_valid), 0);
`endif

        // reset mid-packet discards it without an error
        at_pos();
        reset = 1'b0;
        tick();
        chk("reset_mid_outputs", outs(), 0);
        exp_cmd.delete();
        exp_dat.delete();
        need_hdr = 1'b1;
        rem = 0;
        repeat (2) tick();
        at_pos();
        reset = 1'b1;
        repeat (3) tick();
        chk("reset_mid_idle", 64'(bus.busy), 0);
        chk("reset_mid_no_read", 64'(bus.fifo_read), 0);

        // recovery packet
        beat_log.delete();
        at_pos();
        push(32'h0E000001);
        push(32'h77777777);
        drain("recover");
        chk("recover_beat", 64'(beat_log.size() == 1 ? beat_log[0] : 33'd0), {32'h77777777, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
